// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared widths, FSM state encoding and ROM entry layout for the song sequencer
package song_pkg;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;
   localparam int SONG_W = 2;
   localparam int IDX_W  = 5;
   localparam int ADDR_W = SONG_W + IDX_W;
   localparam int ENTRY_W = NOTE_W + DUR_W;

   localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;
   localparam logic [IDX_W-1:0] LAST_IDX       = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SETTLE,
      WAIT_DONE,
      ADVANCE,
      DONE
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  duration;
   } song_entry_t;

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - four-song note ROM, address {song, idx}, registered output (1-cycle latency)
module song_rom
   import song_pkg::*;
(
   input  logic               clk,
   input  logic [ADDR_W-1:0]  addr,
   output logic [ENTRY_W-1:0] dout
);

   function automatic song_entry_t lookup(input logic [ADDR_W-1:0] a);
      logic [SONG_W-1:0] s;
      logic [IDX_W-1:0]  i;
      song_entry_t       e;
      s = a[ADDR_W-1:IDX_W];
      i = a[IDX_W-1:0];
      e = '0;
      case (s)
         // song 0: 32 playable entries, never hits an end marker
         2'd0: begin
            e.note     = NOTE_W'(12) + NOTE_W'(i);
            e.duration = (i == '0) ? DUR_W'(8) : DUR_W'(i[1:0]) + DUR_W'(1);
         end
         2'd1: begin
            case (i)
               5'd0:    e = {NOTE_W'(20), DUR_W'(3)};
               5'd1:    e = {NOTE_W'(0),  DUR_W'(2)};
               5'd2:    e = {NOTE_W'(22), DUR_W'(4)};
               5'd3:    e = {NOTE_W'(5),  END_MARKER_DUR};
               default: e = {NOTE_W'(1),  DUR_W'(1)};
            endcase
         end
         2'd2: begin
            case (i)
               5'd0:    e = {NOTE_W'(33), DUR_W'(5)};
               5'd1:    e = {NOTE_W'(34), DUR_W'(6)};
               5'd2:    e = {NOTE_W'(0),  END_MARKER_DUR};
               default: e = {NOTE_W'(35), DUR_W'(2)};
            endcase
         end
         default: begin
            e.note     = NOTE_W'(i) + NOTE_W'(1);
            e.duration = DUR_W'(2);
         end
      endcase
      return e;
   endfunction

   always_ff @(posedge clk) begin
      dout <= lookup(addr);
   end

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks the song ROM and feeds note_player via a new_note/note_done handshake
// Optional SONG_LOOP_EN: songs repeat and song_done becomes a one-cycle pulse per pass.
module song_reader
   import song_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic [SONG_W-1:0] song,
   input  logic              note_done,
   output logic [NOTE_W-1:0] note_to_load,
   output logic [DUR_W-1:0]  duration_to_load,
   output logic              new_note,
   output logic              song_done
);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [SONG_W-1:0]   song_q;
   logic [NOTE_W-1:0]   note_q;
   logic [DUR_W-1:0]    dur_q;
   logic [ENTRY_W-1:0]  rom_dout;
   song_entry_t         rom_entry;
   logic                song_changed;
   logic                is_marker;
   logic                end_of_pass;

   song_rom u_rom (
      .clk  (clk),
      .addr ({song_q, idx}),
      .dout (rom_dout)
   );

   assign rom_entry    = song_entry_t'(rom_dout);
   assign song_changed = (song != song_q);
   assign is_marker    = (rom_entry.duration == END_MARKER_DUR);
   assign end_of_pass  = ((state == LOAD) && is_marker) ||
                         ((state == ADVANCE) && (idx == LAST_IDX));

   // The strobe and its data must be valid in the same LOAD cycle, because
   // note_player drops note_done on the edge that samples new_note.
   assign new_note         = play && (state == LOAD) && !is_marker;
   assign note_to_load     = (state == LOAD) ? rom_entry.note : note_q;
   assign duration_to_load = (state == LOAD) ? rom_entry.duration : dur_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         song_q    <= '0;
         note_q    <= '0;
         dur_q     <= '0;
         song_done <= 1'b0;
      end else begin
`ifdef SONG_LOOP_EN
         song_done <= 1'b0;
`endif
         if (song_changed) begin
            song_q    <= song;
            idx       <= '0;
            song_done <= 1'b0;
            state     <= play ? FETCH : IDLE;
         end else if (play) begin
            if (state == LOAD) begin
               note_q <= rom_entry.note;
               dur_q  <= rom_entry.duration;
            end
            if (end_of_pass) begin
               song_done <= 1'b1;
`ifdef SONG_LOOP_EN
               idx       <= '0;
               state     <= FETCH;
`else
               state     <= DONE;
`endif
            end else begin
               case (state)
                  IDLE:      state <= FETCH;
                  FETCH:     state <= LOAD;
                  LOAD:      state <= SETTLE;
                  // note_done is stale for one cycle after a load
                  SETTLE:    state <= WAIT_DONE;
                  WAIT_DONE: if (note_done) state <= ADVANCE;
                  ADVANCE: begin
                     idx   <= idx + 1'b1;
                     state <= FETCH;
                  end
                  DONE:      state <= DONE;
                  default:   state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
